dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_array.sv | 41 ++++
 rtl/dmem_responder.sv | 150 +++++++++++++++
 tb/tb_dmem_responder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and state encoding for the data-memory responder.
package dmem_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Word array with asynchronous clear, one synchronous write port and a registered read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic              rd_clr,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

    // Read data holds between responses; store/error responses clear it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end else if (rd_clr) begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder with programmable wait states and a one-cycle response pulse.
// Optional address range check enabled by defining DMEM_RANGE_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    dmem_state_t       state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;

    logic              lat_write;
    logic              lat_err;
    logic [IDX_W-1:0]  lat_idx;
    logic [DATA_W-1:0] lat_wdata;

    logic              accept_c;
    logic              commit_c;
    logic              in_err_c;
    logic              cur_write_c;
    logic              cur_err_c;
    logic [IDX_W-1:0]  cur_idx_c;
    logic [DATA_W-1:0] cur_wdata_c;

`ifdef DMEM_RANGE_CHECK_EN
    assign in_err_c = (req_addr >= ADDR_W'(DEPTH));
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[ADDR_W-1:IDX_W];
    assign in_err_c       = 1'b0;
`endif

    assign accept_c = req_valid && (state != WAIT);
    assign commit_c = (state_next == RESP);

    // With no wait states the commit edge is the accept edge, so use the live request.
    always_comb begin
        cur_write_c = lat_write;
        cur_err_c   = lat_err;
        cur_idx_c   = lat_idx;
        cur_wdata_c = lat_wdata;
        if (WAIT_CYCLES == 0) begin
            cur_write_c = req_write;
            cur_err_c   = in_err_c;
            cur_idx_c   = req_addr[IDX_W-1:0];
            cur_wdata_c = req_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE, RESP: begin
                if (accept_c) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
        end else if (accept_c) begin
            lat_write <= req_write;
            lat_err   <= in_err_c;
            lat_idx   <= req_addr[IDX_W-1:0];
            lat_wdata <= req_wdata;
        end
    end

    // Handshake and response flags track the next state; rsp_write/rsp_err hold between pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            req_ready <= (state_next != WAIT);
            busy      <= (state_next != IDLE);
            rsp_valid <= commit_c;
            if (commit_c) begin
                rsp_write <= cur_write_c;
                rsp_err   <= cur_err_c;
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk    (clk),
        .reset  (reset),
        .we     (commit_c && cur_write_c && !cur_err_c),
        .re     (commit_c && !cur_write_c && !cur_err_c),
        .rd_clr (commit_c && (cur_write_c || cur_err_c)),
        .idx    (cur_idx_c),
        .wdata  (cur_wdata_c),
        .rdata  (rsp_data)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (0, 1 and 3 wait states) against a word-array reference model.
module tb_dmem_responder;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid [NI];
    logic        req_ready [NI];
    logic        req_write [NI];
    logic [15:0] req_addr  [NI];
    logic [15:0] req_wdata [NI];
    logic        rsp_valid [NI];
    logic        rsp_write [NI];
    logic [15:0] rsp_data  [NI];
    logic        rsp_err   [NI];
    logic        busy      [NI];

    logic [15:0] mem [NI][256];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned WC = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        dmem_responder #(.DEPTH(256), .WAIT_CYCLES(WC)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_write (req_write[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_write (rsp_write[g]),
            .rsp_data  (rsp_data[g]),
            .rsp_err   (rsp_err[g]),
            .busy      (busy[g])
        );
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic int wc_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NI; k++)
            for (int i = 0; i < 256; i++) mem[k][i] = 16'h0000;
    endtask

    // Reference behaviour: out-of-range requests are errors only with the range check built in.
    task automatic model(input int k, input bit w, input logic [15:0] a, input logic [15:0] d,
                         output logic [15:0] ed, output logic ee);
        int idx;
        idx = int'(a) % 256;
`ifdef DMEM_RANGE_CHECK_EN
        ee = (int'(a) >= 256);
`else
        ee = 1'b0;
`endif
        ed = 16'h0000;
        if (w) begin
            if (!ee) mem[k][idx] = d;
        end else if (!ee) begin
            ed = mem[k][idx];
        end
    endtask

    // One request from a negedge; checks accept, latency, pulse width and hold.
    task automatic xact(input int k, input bit w, input logic [15:0] a, input logic [15:0] d,
                        input string tag);
        logic [15:0] ed;
        logic        ee;
        bit          acc;
        req_valid[k] = 1'b1;
        req_write[k] = w;
        req_addr[k]  = a;
        req_wdata[k] = d;
        acc = 1'b0;
        for (int c = 0; c < 16 && !acc; c++) begin
            acc = req_ready[k];
            @(negedge clk);
        end
        req_valid[k] = 1'b0;
        chk1({tag, "_accept"}, acc, 1'b1);
        if (!acc) return;
        model(k, w, a, d, ed, ee);
        chk1({tag, "_busy"}, busy[k], 1'b1);
        for (int i = 0; i < wc_of(k); i++) begin
            chk1({tag, "_early"}, rsp_valid[k], 1'b0);
            @(negedge clk);
        end
        chk1({tag, "_valid"}, rsp_valid[k], 1'b1);
        chk1({tag, "_write"}, rsp_write[k], w);
        chk16({tag, "_data"}, rsp_data[k], ed);
        chk1({tag, "_err"}, rsp_err[k], ee);
        @(negedge clk);
        chk1({tag, "_pulse"}, rsp_valid[k], 1'b0);
        chk16({tag, "_hold"}, rsp_data[k], ed);
    endtask

    initial begin
        logic [15:0] ed;
        logic        ee;
        for (int k = 0; k < NI; k++) begin
            req_valid[k] = 1'b0;
            req_write[k] = 1'b0;
            req_addr[k]  = 16'h0000;
            req_wdata[k] = 16'h0000;
        end
        model_clear();
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk1("rst_rsp_valid", rsp_valid[k], 1'b0);
            chk1("rst_rsp_write", rsp_write[k], 1'b0);
            chk16("rst_rsp_data", rsp_data[k], 16'h0000);
            chk1("rst_rsp_err", rsp_err[k], 1'b0);
            chk1("rst_busy", busy[k], 1'b0);
            chk1("rst_ready", req_ready[k], 1'b1);
        end
        reset = 1'b0;
        @(negedge clk);

        // Store then load with one wait state.
        xact(1, 1'b1, 16'h0010, 16'hBEEF, "st_beef");
        xact(1, 1'b0, 16'h0010, 16'h0000, "ld_beef");

        // Zero wait states: back-to-back loads with valid held.
        for (int i = 0; i < 4; i++) xact(0, 1'b1, 16'(i), 16'(i + 1), "st_b2b");
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_addr[0] = 16'(i);
            chk1("b2b_ready", req_ready[0], 1'b1);
            model(0, 1'b0, 16'(i), 16'h0000, ed, ee);
            @(negedge clk);
            chk1("b2b_valid", rsp_valid[0], 1'b1);
            chk16("b2b_data", rsp_data[0], ed);
        end
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk1("b2b_end", rsp_valid[0], 1'b0);

        // Three wait states: second request stalls until the RESP cycle.
        req_valid[2] = 1'b1;
        req_write[2] = 1'b1;
        req_addr[2]  = 16'h0020;
        req_wdata[2] = 16'h5A5A;
        chk1("ovl_ready0", req_ready[2], 1'b1);
        model(2, 1'b1, 16'h0020, 16'h5A5A, ed, ee);
        @(negedge clk);
        req_write[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk1("ovl_ready_wait", req_ready[2], 1'b0);
            chk1("ovl_no_rsp", rsp_valid[2], 1'b0);
            @(negedge clk);
        end
        chk1("ovl_ready_resp", req_ready[2], 1'b1);
        chk1("ovl_st_valid", rsp_valid[2], 1'b1);
        chk1("ovl_st_write", rsp_write[2], 1'b1);
        model(2, 1'b0, 16'h0020, 16'h0000, ed, ee);
        @(negedge clk);
        req_valid[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk1("ovl_ld_early", rsp_valid[2], 1'b0);
            @(negedge clk);
        end
        chk1("ovl_ld_valid", rsp_valid[2], 1'b1);
        chk1("ovl_ld_write", rsp_write[2], 1'b0);
        chk16("ovl_ld_data", rsp_data[2], ed);
        @(negedge clk);

        // Upper address bits: wrap or range error depending on build.
        xact(1, 1'b1, 16'h0105, 16'h1234, "st_hi");
        xact(1, 1'b0, 16'h0005, 16'h0000, "ld_wrap");
        xact(1, 1'b0, 16'h0105, 16'h0000, "ld_hi");

        // Reset during WAIT of a store drops it.
        req_valid[2] = 1'b1;
        req_write[2] = 1'b1;
        req_addr[2]  = 16'h0007;
        req_wdata[2] = 16'hAAAA;
        @(negedge clk);
        req_valid[2] = 1'b0;
        chk1("mid_busy", busy[2], 1'b1);
        reset = 1'b1;
        #1;
        chk1("mid_rst_valid", rsp_valid[2], 1'b0);
        chk1("mid_rst_busy", busy[2], 1'b0);
        chk1("mid_rst_ready", req_ready[2], 1'b1);
        chk16("mid_rst_data", rsp_data[2], 16'h0000);
        chk1("mid_rst_write", rsp_write[2], 1'b0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk1("mid_no_rsp", rsp_valid[2], 1'b0);
            @(negedge clk);
        end
        xact(2, 1'b0, 16'h0007, 16'h0000, "ld_after_rst");
        xact(1, 1'b0, 16'h0033, 16'h0000, "ld_fresh");

        // Randomized traffic on every instance.
        for (int k = 0; k < NI; k++) begin
            for (int n = 0; n < 30; n++) begin
                xact(k, 1'($urandom_range(0, 1)),
                     16'($urandom_range(0, 1) * 256 + $urandom_range(0, 7)),
                     16'($urandom), "rnd");
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) @(negedge clk);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
